// File: rtl/hb_bootloader.sv
// Byte-stream loader: holds the core in reset, writes a length-prefixed image to program memory
// from address 0, then releases the core on a good checksum or latches an error on any failure.
module hb_bootloader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_btn_b,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              bl_done,
  output logic              bl_error,
  output logic              cpu_rst_b
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

  state_t          state;
  logic [7:0]      len_hi;
  logic [15:0]     remaining;
  logic [7:0]      sum;
  logic [ADDR_W:0] addr;

  logic        accept;
  logic [15:0] len_n;
  logic [7:0]  csum_total;

  assign accept     = in_valid && in_ready;
  assign len_n      = {len_hi, in_data};
  assign csum_total = sum + in_data;
  assign cpu_rst_b  = bl_done;

  always_ff @(posedge clk) begin
    if (!rst_btn_b) begin
      state     <= S_LEN_HI;
      len_hi    <= 8'd0;
      remaining <= 16'd0;
      sum       <= 8'd0;
      addr      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      bl_done   <= 1'b0;
      bl_error  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // in_ready comes up one cycle after reset release; terminal states clear it below.
      if (state == S_LEN_HI) in_ready <= 1'b1;
      if (accept) begin
        case (state)
          S_LEN_HI: begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            remaining <= len_n;
            if (len_n == 16'd0) begin
              state <= S_CSUM;
            end else if ({1'b0, len_n} > MAX_LEN) begin
              state    <= S_ERR;
              bl_error <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            // The top address bit can only be set after the final write, so it gates nothing real.
            mem_we    <= !addr[ADDR_W];
            mem_addr  <= addr[ADDR_W-1:0];
            mem_wdata <= in_data;
            sum       <= sum + in_data;
            addr      <= addr + 1'b1;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= S_CSUM;
          end
          S_CSUM: begin
            in_ready <= 1'b0;
            if (csum_total == 8'd0) begin
              state   <= S_DONE;
              bl_done <= 1'b1;
            end else begin
              state    <= S_ERR;
              bl_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hb_bootloader.sv
// Directed bench for hb_bootloader: good/bad/zero/oversize/full-size frames, throttling, mid-frame reset.
module tb_hb_bootloader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_btn_b;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              bl_done;
  logic              bl_error;
  logic              cpu_rst_b;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  logic throttle = 1'b0;

  hb_bootloader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_btn_b(rst_btn_b), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .bl_done(bl_done), .bl_error(bl_error), .cpu_rst_b(cpu_rst_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_wdata));
      wr_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Present one byte; returns just after the edge that accepts it.
  task automatic send(input logic [7:0] b);
    int budget;
    budget = 0;
    if (throttle) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_btn_b = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    clear_log();
    rst_btn_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_good3();
    send(8'h00); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'hA0);
  endtask

  task automatic test_reset();
    in_data   = 8'h00;
    in_valid  = 1'b0;
    rst_btn_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, bl_done, bl_error, cpu_rst_b} !== 21'd0)
      $display("FAIL reset_outputs: got rdy=%0b we=%0b addr=%0h wd=%0h done=%0b err=%0b cpu=%0b required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, bl_done, bl_error, cpu_rst_b);
    else pass_cnt++;
    rst_btn_b = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready_rise: in_ready=%0b required 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_good();
    do_reset();
    send_good3();
    #1;
    chk_cnt++;
    if (bl_done !== 1'b1 || cpu_rst_b !== 1'b1 || bl_error !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL good_done: done=%0b cpu=%0b err=%0b rdy=%0b required 1 1 0 0", bl_done, cpu_rst_b, bl_error, in_ready);
    else pass_cnt++;
    idle();
    @(negedge clk);
    chk_cnt++;
    if (wr_addr.size() !== 3) $display("FAIL good_count: writes=%0d required 3", wr_addr.size());
    else pass_cnt++;
    if (wr_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk_cnt++;
        if (wr_addr[i] !== i || wr_data[i] !== 16 * (i + 1) || wr_cyc[i] !== wr_cyc[0] + i)
          $display("FAIL good_write%0d: addr=%0h data=%0h cyc+%0d required %0h %0h +%0d",
                   i, wr_addr[i], wr_data[i], wr_cyc[i] - wr_cyc[0], i, 16 * (i + 1), i);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    send(8'h00); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'hA1);
    #1;
    chk_cnt++;
    if (bl_error !== 1'b1 || bl_done !== 1'b0 || cpu_rst_b !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL bad_csum_flags: err=%0b done=%0b cpu=%0b rdy=%0b required 1 0 0 0", bl_error, bl_done, cpu_rst_b, in_ready);
    else pass_cnt++;
    idle();
    @(negedge clk);
    chk_cnt++;
    if (wr_addr.size() !== 3 || wr_data.size() !== 3 || wr_data[2] !== 8'h30)
      $display("FAIL bad_csum_writes: writes=%0d required 3 ending in 30", wr_addr.size());
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    do_reset();
    send(8'h00); send(8'h00); send(8'h00);
    #1;
    chk_cnt++;
    if (bl_done !== 1'b1 || bl_error !== 1'b0 || wr_addr.size() !== 0)
      $display("FAIL zero_len: done=%0b err=%0b writes=%0d required 1 0 0", bl_done, bl_error, wr_addr.size());
    else pass_cnt++;
    idle();
  endtask

  task automatic test_oversize();
    do_reset();
    send(8'h01); send(8'h01);
    #1;
    chk_cnt++;
    if (bl_error !== 1'b1 || bl_done !== 1'b0 || in_ready !== 1'b0 || wr_addr.size() !== 0)
      $display("FAIL oversize: err=%0b done=%0b rdy=%0b writes=%0d required 1 0 0 0", bl_error, bl_done, in_ready, wr_addr.size());
    else pass_cnt++;
    idle();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (bl_error !== 1'b1 || wr_addr.size() !== 0)
      $display("FAIL oversize_sticky: err=%0b writes=%0d required 1 0", bl_error, wr_addr.size());
    else pass_cnt++;
  endtask

  task automatic test_full_size();
    int bad;
    bad = 0;
    do_reset();
    send(8'h01); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
    // Sum of 0..255 is 0x7F80, so C = 0x80.
    send(8'h80);
    #1;
    chk_cnt++;
    if (bl_done !== 1'b1 || bl_error !== 1'b0)
      $display("FAIL full_done: done=%0b err=%0b required 1 0", bl_done, bl_error);
    else pass_cnt++;
    idle();
    @(negedge clk);
    chk_cnt++;
    if (wr_addr.size() !== 256) $display("FAIL full_count: writes=%0d required 256", wr_addr.size());
    else pass_cnt++;
    for (int i = 0; i < wr_addr.size() && i < 256; i++)
      if (wr_addr[i] !== i || wr_data[i] !== i) bad++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL full_writes: bad entries=%0d required 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_throttled();
    do_reset();
    throttle = 1'b1;
    send_good3();
    throttle = 1'b0;
    #1;
    chk_cnt++;
    if (bl_done !== 1'b1 || bl_error !== 1'b0)
      $display("FAIL throttle_done: done=%0b err=%0b required 1 0", bl_done, bl_error);
    else pass_cnt++;
    idle();
    @(negedge clk);
    chk_cnt++;
    if (wr_addr.size() !== 3) $display("FAIL throttle_count: writes=%0d required 3", wr_addr.size());
    else pass_cnt++;
    if (wr_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk_cnt++;
        if (wr_addr[i] !== i || wr_data[i] !== 16 * (i + 1))
          $display("FAIL throttle_write%0d: addr=%0h data=%0h required %0h %0h", i, wr_addr[i], wr_data[i], i, 16 * (i + 1));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    send(8'h00); send(8'h03); send(8'h10); send(8'h20);
    @(negedge clk);
    rst_btn_b = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (mem_we !== 1'b0 || in_ready !== 1'b0 || mem_addr !== 8'h00)
      $display("FAIL midreset_outputs: we=%0b rdy=%0b addr=%0h required 0 0 0", mem_we, in_ready, mem_addr);
    else pass_cnt++;
    clear_log();
    rst_btn_b = 1'b1;
    send_good3();
    #1;
    chk_cnt++;
    if (bl_done !== 1'b1 || bl_error !== 1'b0)
      $display("FAIL midreset_done: done=%0b err=%0b required 1 0", bl_done, bl_error);
    else pass_cnt++;
    idle();
    @(negedge clk);
    chk_cnt++;
    if (wr_addr.size() !== 3 || wr_addr[0] !== 0 || wr_data[0] !== 8'h10 || wr_addr[2] !== 2 || wr_data[2] !== 8'h30)
      $display("FAIL midreset_writes: writes=%0d required 3 starting at addr 0 data 10", wr_addr.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_csum();
    test_zero_len();
    test_oversize();
    test_full_size();
    test_throttled();
    test_reset_mid_data();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
